// File: rtl/imm_decode_stage.sv
// Registered immediate-generation stage between fetch and execute. Holds up to two
// decoded entries (output register + skid entry) so in_ready never depends on out_ready.
module imm_decode_stage #(
  parameter int XLEN     = 32,
  parameter bit FLUSH_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    fmt_t            fmt;
  } entry_t;

  entry_t          dec;
  entry_t          out_q;
  entry_t          skid_q;
  logic            out_valid_q;
  logic            skid_full_q;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  fmt_t            fmt;
  logic            kill;
  logic            accept;
  logic            drain;
  logic            out_load;

  // Every format fits in 32 bits; widening to XLEN is a plain sign-extension from bit 31.
  always_comb begin
    imm32 = '0;
    fmt   = FMT_NONE;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        fmt   = FMT_I;
      end
      7'b0100011: begin
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        fmt   = FMT_S;
      end
      7'b1100011: begin
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
        fmt   = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        imm32 = {in_instr[31:12], 12'b0};
        fmt   = FMT_U;
      end
      7'b1101111: begin
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
        fmt   = FMT_J;
      end
      7'b1110011: begin
        if (in_instr[14]) begin
          imm32 = {27'b0, in_instr[19:15]};
          fmt   = FMT_Z;
        end
      end
      default: ;
    endcase
    imm_ext       = {XLEN{imm32[31]}};
    imm_ext[31:0] = imm32;
  end

  always_comb begin
    dec.instr  = in_instr;
    dec.pc     = in_pc;
    dec.imm    = imm_ext;
    dec.target = in_pc + imm_ext;
    dec.fmt    = fmt;
  end

  assign kill     = FLUSH_EN ? flush : 1'b0;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;
  assign out_load = !out_valid_q || drain;

  // The skid entry, when full, always refills the output register before new input does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else if (kill) begin
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else if (out_load) begin
      out_valid_q <= skid_full_q || accept;
      skid_full_q <= 1'b0;
    end else if (accept) begin
      skid_full_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else if (!kill) begin
      if (out_load) begin
        if (skid_full_q) begin
          out_q <= skid_q;
        end else if (accept) begin
          out_q <= dec;
        end
      end else if (accept) begin
        skid_q <= dec;
      end
    end
  end

  assign in_ready   = !skid_full_q;
  assign out_valid  = out_valid_q;
  assign out_imm    = out_q.imm;
  assign out_fmt    = out_q.fmt;
  assign out_target = out_q.target;
  assign out_pc     = out_q.pc;
  assign out_instr  = out_q.instr;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: fixed decode vectors, stall/flush/reset sequences and a
// randomized run, with a FIFO scoreboard shared by an RV32 and an RV64 instance.
module tb_imm_decode_stage;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr  = '0;
  logic [63:0] in_pc64   = '0;
  logic [31:0] in_pc32;

  logic        in_ready, out_valid;
  logic [31:0] out_imm, out_target, out_pc, out_instr;
  logic [2:0]  out_fmt;
  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64, out_target64, out_pc64;
  logic [31:0] out_instr64;
  logic [2:0]  out_fmt64;

  int passed = 0;
  int total  = 0;

  assign in_pc32 = in_pc64[31:0];

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .FLUSH_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc32),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_target(out_target), .out_pc(out_pc), .out_instr(out_instr)
  );

  imm_decode_stage #(.XLEN(64), .FLUSH_EN(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_target(out_target64), .out_pc(out_pc64), .out_instr(out_instr64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [31:0] target;
  } vec_t;

  exp_t sbq[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Reference decode built from field positions with shifts and masks on a 64-bit value.
  function automatic void refDecode(input logic [31:0] instr, output logic [63:0] imm,
                                    output logic [2:0] fmt);
    logic [63:0] s64;
    logic [63:0] t;
    s64 = {{32{instr[31]}}, instr};
    t   = $signed(s64) >>> 31;
    imm = '0;
    fmt = 3'd0;
    case (instr[6:0])
      7'h13, 7'h03, 7'h67: begin imm = $signed(s64) >>> 20; fmt = 3'd1; end
      7'h23: begin
        imm = (t << 11) | ((s64 >> 25) << 5) | ((s64 >> 7) & 64'h1F);
        fmt = 3'd2;
      end
      7'h63: begin
        imm = (t << 12) | (((s64 >> 7) & 64'h1) << 11) | (((s64 >> 25) & 64'h3F) << 5)
              | (((s64 >> 8) & 64'hF) << 1);
        fmt = 3'd3;
      end
      7'h37, 7'h17: begin imm = (s64 >> 12) << 12; fmt = 3'd4; end
      7'h6F: begin
        imm = (t << 20) | (((s64 >> 12) & 64'hFF) << 12) | (((s64 >> 20) & 64'h1) << 11)
              | (((s64 >> 21) & 64'h3FF) << 1);
        fmt = 3'd5;
      end
      7'h73: begin
        if (((s64 >> 14) & 64'h1) != 64'h0) begin
          imm = (s64 >> 15) & 64'h1F;
          fmt = 3'd6;
        end
      end
      default: ;
    endcase
  endfunction

  always @(negedge rst_n) sbq.delete();

  // Inputs are stable from posedge+1 to the next posedge, so the negedge sees what that edge will do.
  always @(negedge clk) begin
    bit   mvalid;
    bit   mready;
    exp_t e;
    exp_t n;
    if (rst_n) begin
      mvalid = sbq.size() > 0;
      mready = sbq.size() < 2;
      checkOutput("out_valid32", {63'b0, out_valid}, {63'b0, mvalid});
      checkOutput("in_ready32", {63'b0, in_ready}, {63'b0, mready});
      checkOutput("out_valid64", {63'b0, out_valid64}, {63'b0, mvalid});
      checkOutput("in_ready64", {63'b0, in_ready64}, {63'b0, mready});
      if (mvalid && out_ready) begin
        e = sbq.pop_front();
        checkOutput("sb_instr", {32'b0, out_instr}, {32'b0, e.instr});
        checkOutput("sb_pc32", {32'b0, out_pc}, {32'b0, e.pc[31:0]});
        checkOutput("sb_imm32", {32'b0, out_imm}, {32'b0, e.imm[31:0]});
        checkOutput("sb_fmt", {61'b0, out_fmt}, {61'b0, e.fmt});
        checkOutput("sb_target32", {32'b0, out_target}, {32'b0, e.pc[31:0] + e.imm[31:0]});
        checkOutput("sb_imm64", out_imm64, e.imm);
        checkOutput("sb_pc64", out_pc64, e.pc);
        checkOutput("sb_target64", out_target64, e.pc + e.imm);
      end
      if (flush) begin
        sbq.delete();
      end else if (in_valid && mready) begin
        n.instr = in_instr;
        n.pc    = in_pc64;
        refDecode(in_instr, n.imm, n.fmt);
        sbq.push_back(n);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc64  = {$urandom(), pc};
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  vec_t        vecs[10];
  logic [6:0]  ops[11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73,
                           7'h33, 7'h0F};
  logic [31:0] r;

  initial begin
    vecs[0] = '{"addi", 32'hFFF00093, 32'h0,   64'hFFFFFFFFFFFFFFFF, 3'd1, 32'hFFFFFFFF};
    vecs[1] = '{"sw",   32'hFE112E23, 32'h4,   64'hFFFFFFFFFFFFFFFC, 3'd2, 32'h00000000};
    vecs[2] = '{"beq",  32'hFE000CE3, 32'h100, 64'hFFFFFFFFFFFFFFF8, 3'd3, 32'h000000F8};
    vecs[3] = '{"lui",  32'h123450B7, 32'h8,   64'h0000000012345000, 3'd4, 32'h12345008};
    vecs[4] = '{"csri", 32'h3002D073, 32'hC,   64'h0000000000000005, 3'd6, 32'h00000011};
    vecs[5] = '{"add",  32'h00000033, 32'h10,  64'h0000000000000000, 3'd0, 32'h00000010};
    vecs[6] = '{"jal",  32'h008000EF, 32'h20,  64'h0000000000000008, 3'd5, 32'h00000028};
    vecs[7] = '{"csrw", 32'h30029073, 32'h24,  64'h0000000000000000, 3'd0, 32'h00000024};
    vecs[8] = '{"lw",   32'h0040A103, 32'h28,  64'h0000000000000004, 3'd1, 32'h0000002C};
    vecs[9] = '{"luin", 32'h800000B7, 32'h2C,  64'hFFFFFFFF80000000, 3'd4, 32'h8000002C};

    @(posedge clk); #1;
    checkOutput("rst_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("rst_in_ready", {63'b0, in_ready}, 64'd1);
    checkOutput("rst_out_imm", {32'b0, out_imm}, 64'd0);
    checkOutput("rst_out_fmt", {61'b0, out_fmt}, 64'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].pc);
      checkOutput({vecs[i].name, "_valid"}, {63'b0, out_valid}, 64'd1);
      checkOutput({vecs[i].name, "_imm32"}, {32'b0, out_imm}, {32'b0, vecs[i].imm[31:0]});
      checkOutput({vecs[i].name, "_fmt"}, {61'b0, out_fmt}, {61'b0, vecs[i].fmt});
      checkOutput({vecs[i].name, "_target"}, {32'b0, out_target}, {32'b0, vecs[i].target});
      checkOutput({vecs[i].name, "_imm64"}, out_imm64, vecs[i].imm);
    end
    @(posedge clk); #1;

    // Back-pressure: A fills the output, B the skid, C waits until A drains.
    out_ready = 1'b0;
    applyStimulus(32'h00100093, 32'h200);
    checkOutput("stall_a_out", {32'b0, out_instr}, 64'h00100093);
    checkOutput("stall_a_ready", {63'b0, in_ready}, 64'd1);
    applyStimulus(32'h00200093, 32'h204);
    checkOutput("stall_b_ready", {63'b0, in_ready}, 64'd0);
    checkOutput("stall_b_hold", {32'b0, out_instr}, 64'h00100093);
    in_valid = 1'b1;
    in_instr = 32'h00300093;
    in_pc64  = 64'h208;
    @(posedge clk); #1;
    checkOutput("stall_c_ready", {63'b0, in_ready}, 64'd0);
    checkOutput("stall_c_hold", {32'b0, out_instr}, 64'h00100093);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("drain_b_out", {32'b0, out_instr}, 64'h00200093);
    checkOutput("drain_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("drain_c_out", {32'b0, out_instr}, 64'h00300093);
    @(posedge clk); #1;
    checkOutput("drain_empty", {63'b0, out_valid}, 64'd0);

    // Flush wins over an accept that in_ready would have allowed.
    out_ready = 1'b0;
    applyStimulus(32'h00400093, 32'h300);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00500093;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush1_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("flush1_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("flush1_gone", {63'b0, out_valid}, 64'd0);
    end

    out_ready = 1'b0;
    applyStimulus(32'h00600093, 32'h400);
    applyStimulus(32'h00700093, 32'h404);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00800093;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush2_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("flush2_ready", {63'b0, in_ready}, 64'd1);
    checkOutput("flush2_valid64", {63'b0, out_valid64}, 64'd0);

    // Asynchronous reset while the skid is full.
    applyStimulus(32'h00900093, 32'h500);
    applyStimulus(32'h00A00093, 32'h504);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("arst_ready", {63'b0, in_ready}, 64'd1);
    checkOutput("arst_imm", {32'b0, out_imm}, 64'd0);
    checkOutput("arst_instr", {32'b0, out_instr}, 64'd0);
    checkOutput("arst_target", {32'b0, out_target}, 64'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(32'h00500093, 32'h600);
    checkOutput("post_rst_valid", {63'b0, out_valid}, 64'd1);
    checkOutput("post_rst_instr", {32'b0, out_instr}, 64'h00500093);
    checkOutput("post_rst_imm", {32'b0, out_imm}, 64'd5);

    for (int i = 0; i < 3000; i++) begin
      r         = $urandom();
      in_instr  = {r[31:7], ops[$urandom_range(0, 10)]};
      in_pc64   = {$urandom(), $urandom()};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
